// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock,
// LSB first, one registered borrow between digits.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             br;
    logic             am;
    logic             bm;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [DIGIT-1:0] dig;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] rd_nxt;

    assign accept = start && (state == IDLE || state == DONE);

    // Ripple one digit of full-subtractor cells from the stored borrow.
    always_comb begin
        dig      = '0;
        chain    = '0;
        chain[0] = br;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i]     = ra[i] ^ rb[i] ^ chain[i];
            chain[i+1] = (~ra[i] & rb[i]) | (~(ra[i] ^ rb[i]) & chain[i]);
        end
    end

    // Partial result enters from the MSB side; the final digit joins
    // combinationally so the accumulator only holds WIDTH-DIGIT bits.
    generate
        if (N > 1) begin : g_acc
            logic [WIDTH-DIGIT-1:0] acc;

            // Accumulate finished digits while running.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc <= '0;
                end else if (accept) begin
                    acc <= '0;
                end else if (state == RUN) begin
                    acc <= rd_nxt[WIDTH-1:DIGIT];
                end
            end

            assign rd_nxt = {dig, acc};
        end else begin : g_one
            assign rd_nxt = dig;
        end
    endgenerate

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            br    <= 1'b0;
            am    <= 1'b0;
            bm    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ra    <= a;
                rb    <= b;
                br    <= bin;
                am    <= a[WIDTH-1];
                bm    <= b[WIDTH-1];
                cnt   <= '0;
                busy  <= 1'b1;
                state <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        ra <= ra >> DIGIT;
                        rb <= rb >> DIGIT;
                        br <= chain[DIGIT];
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            diff  <= rd_nxt;
                            bout  <= chain[DIGIT];
                            ovf   <= (am != bm) && (rd_nxt[WIDTH-1] != am);
                            state <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: W8/D1 vectors and handshake,
// exhaustive W4/D2 and W4/D4 against an arithmetic reference.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start42 = 1'b0;
    logic [3:0] a42 = '0;
    logic [3:0] b42 = '0;
    logic       bin42 = 1'b0;
    logic       busy42, done42, bout42, ovf42;
    logic [3:0] diff42;

    logic       start44 = 1'b0;
    logic [3:0] a44 = '0;
    logic [3:0] b44 = '0;
    logic       bin44 = 1'b0;
    logic       busy44, done44, bout44, ovf44;
    logic [3:0] diff44;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst(rst), .start(start42), .a(a42), .b(b42), .bin(bin42),
        .busy(busy42), .done(done42), .diff(diff42), .bout(bout42), .ovf(ovf42)
    );

    serial_subtractor #(.WIDTH(4), .DIGIT(4)) u44 (
        .clk(clk), .rst(rst), .start(start44), .a(a44), .b(b44), .bin(bin44),
        .busy(busy44), .done(done44), .diff(diff44), .bout(bout44), .ovf(ovf44)
    );

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Issue one op on the 8-bit unit; lat counts edges from the accepting
    // edge (1) to the first sample showing done. pmask bit k re-pulses
    // start during RUN cycle k with junk operands.
    task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                        input int pmask, input bit sync, output int lat);
        if (sync) @(negedge clk);
        a8 = xa;
        b8 = xb;
        bin8 = xbin;
        start8 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start8 = ((pmask >> lat) & 1) != 0;
            a8 = 8'hAA;
            b8 = 8'h55;
            bin8 = 1'b1;
            if (lat == 1) chk("busy8_run", {31'd0, busy8}, 32'd1);
        end while (!done8 && lat < 40);
    endtask

    task automatic run42(input logic [3:0] xa, input logic [3:0] xb, input logic xbin,
                         output int lat);
        @(negedge clk);
        a42 = xa;
        b42 = xb;
        bin42 = xbin;
        start42 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start42 = 1'b0;
            a42 = ~xa;
        end while (!done42 && lat < 20);
    endtask

    task automatic run44(input logic [3:0] xa, input logic [3:0] xb, input logic xbin,
                         output int lat);
        @(negedge clk);
        a44 = xa;
        b44 = xb;
        bin44 = xbin;
        start44 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start44 = 1'b0;
            b44 = ~xb;
        end while (!done44 && lat < 20);
    endtask

    initial begin
        int lat;
        int ndone;
        int r;
        logic [4:0] rr;
        logic ov;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_flags", {30'd0, bout8, ovf8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h05, 8'h03, 1'b0, 0, 1'b1, lat);
        chk("lat_05_03", lat, 9);
        chk("res_05_03", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h02});

        run8(8'h00, 8'h01, 1'b0, 0, 1'b1, lat);
        chk("res_00_01", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b1, 8'hFF});

        run8(8'h00, 8'h00, 1'b1, 0, 1'b1, lat);
        chk("res_00_00_b", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b1, 8'hFF});

        run8(8'h80, 8'h01, 1'b0, 0, 1'b1, lat);
        chk("res_80_01", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b1, 1'b0, 8'h7F});

        run8(8'h7F, 8'hFF, 1'b0, 0, 1'b1, lat);
        chk("res_7f_ff", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b1, 1'b1, 8'h80});

        run8(8'h5A, 8'h5A, 1'b0, 0, 1'b1, lat);
        chk("res_eq", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h00});

        repeat (4) @(posedge clk);
        #1;
        chk("done_single", {31'd0, done8}, 32'd0);
        chk("diff_hold", {24'd0, diff8}, 32'd0);

        // Start re-pulsed on RUN cycles 2 and 5 must be ignored.
        run8(8'h05, 8'h03, 1'b0, 32'h24, 1'b1, lat);
        chk("ign_lat", lat, 9);
        chk("ign_res", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h02});
        @(posedge clk);
        #1;
        chk("ign_idle", {30'd0, busy8, done8}, 32'd0);

        // Back-to-back: start held during DONE.
        run8(8'h10, 8'h01, 1'b0, 0, 1'b1, lat);
        chk("b2b_lat1", lat, 9);
        chk("b2b_res1", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h0F});
        run8(8'h01, 8'h10, 1'b1, 0, 1'b0, lat);
        chk("b2b_lat2", lat, 9);
        chk("b2b_res2", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b1, 8'hF0});

        // Reset in RUN cycle 3 discards the op.
        @(negedge clk);
        a8 = 8'h33;
        b8 = 8'h11;
        bin8 = 1'b0;
        start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start8 = 1'b0;
        end
        chk("pre_rst_busy", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
        chk("mid_rst_done", {31'd0, done8}, 32'd0);
        chk("mid_rst_diff", {24'd0, diff8}, 32'd0);
        chk("mid_rst_flags", {30'd0, bout8, ovf8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) ndone++;
        end
        chk("no_done_after_rst", ndone, 0);
        run8(8'h33, 8'h11, 1'b0, 0, 1'b1, lat);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_res", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h22});

        // Exhaustive 4-bit units against the arithmetic reference.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    r = x - y - c;
                    rr = r[4:0];
                    ov = (x[3] != y[3]) && (rr[3] != x[3]);
                    run42(x[3:0], y[3:0], c[0], lat);
                    chk("d2_lat", lat, 3);
                    chk("d2_res", {26'd0, ovf42, bout42, diff42}, {26'd0, ov, rr});
                    run44(x[3:0], y[3:0], c[0], lat);
                    chk("d4_lat", lat, 2);
                    chk("d4_res", {26'd0, ovf44, bout44, diff44}, {26'd0, ov, rr});
                end
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
